// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Access encodings follow the RV32I funct3 field.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int XLEN_DEF = 32;
    localparam int STRB_W   = XLEN_DEF / 8;

    // Stores accept only B/H/W; loads add the unsigned variants.
    function automatic logic f3_illegal(
        input logic       st,
        input logic [2:0] f3
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!st) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return !ok;
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0.
    function automatic logic f3_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; inputs are the captured access fields.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   ldata_o
);

    localparam int SBW = XLEN / 8;

    logic [XLEN-1:0] shifted;
    logic [7:0]      lb;
    logic [15:0]     lh;

    assign shifted = rdata_i >> {offset_i, 3'b000};
    assign lb      = shifted[7:0];
    assign lh      = shifted[15:0];

    // Store strobes and replicated write data; loads drive no lanes.
    always_comb begin
        wstrb_o = '0;
        wdata_o = '0;
        if (is_store_i) begin
            unique case (funct3_i)
                F3_B: begin
                    wstrb_o = SBW'(1) << offset_i;
                    wdata_o = {SBW{store_data_i[7:0]}};
                end
                F3_H: begin
                    wstrb_o = SBW'(3) << offset_i;
                    wdata_o = {(XLEN/16){store_data_i[15:0]}};
                end
                F3_W: begin
                    wstrb_o = '1;
                    wdata_o = store_data_i;
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed byte/halfword and extend it to XLEN.
    always_comb begin
        ldata_o = '0;
        if (!is_store_i) begin
            unique case (funct3_i)
                F3_B:    ldata_o = {{(XLEN-8){lb[7]}}, lb};
                F3_H:    ldata_o = {{(XLEN-16){lh[15]}}, lh};
                F3_W:    ldata_o = rdata_i;
                F3_BU:   ldata_o = {{(XLEN-8){1'b0}}, lb};
                F3_HU:   ldata_o = {{(XLEN-16){1'b0}}, lh};
                default: ldata_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one word-aligned req/gnt/rvalid access per start.
// Holds the pipeline through lsu_busy and flags misalign/illegal/timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              lsu_busy,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              access_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic            st_q, st_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic [XLEN-1:0] ldata_q, ldata_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;

    logic [XLEN/8-1:0] strb;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   ldata;
    logic              tout;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .is_store_i  (st_q),
        .funct3_i    (f3_q),
        .offset_i    (addr_q[1:0]),
        .store_data_i(sdata_q),
        .rdata_i     (mem_rdata),
        .wstrb_o     (strb),
        .wdata_o     (wdata),
        .ldata_o     (ldata)
    );

    assign tout = (tcnt_q == TO_LAST);

    // Next-state: capture on start, bus handshake, timeout abort.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        tcnt_d  = tcnt_q;
        ldata_d = ldata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    st_d    = is_store;
                    f3_d    = funct3;
                    addr_d  = addr;
                    sdata_d = store_data;
                    tcnt_d  = '0;
                    ldata_d = '0;
                    mis_d   = 1'b0;
                    err_d   = 1'b0;
                    if (f3_illegal(is_store, funct3)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (f3_misaligned(funct3, addr[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                tcnt_d = tcnt_q + 1'b1;
                if (tout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (mem_rvalid) begin
                    ldata_d = st_q ? '0 : ldata;
                    state_d = DONE;
                end else if (tout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ldata_d = '0;
                mis_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            tcnt_q  <= '0;
            ldata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            tcnt_q  <= tcnt_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign lsu_busy   = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign load_data  = ldata_q;
    assign misaligned = mis_q;
    assign access_err = err_q;
    assign mem_req    = (state_q == REQ);
    assign mem_we     = mem_req & st_q;
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wstrb  = mem_req ? strb : '0;
    assign mem_wdata  = wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Inputs and samples both happen on the falling edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        lsu_busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .XLEN(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .store_data(store_data),
        .lsu_busy  (lsu_busy),
        .done      (done),
        .load_data (load_data),
        .misaligned(misaligned),
        .access_err(access_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        start = 1'b1;
        is_store = st;
        funct3 = f3;
        addr = a;
        store_data = d;
        tick();
        start = 1'b0;
    endtask

    task automatic load_fast(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] rd,
                             input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        check({tag, " wstrb"}, 32'(mem_wstrb), 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0;
        check({tag, " done"}, 32'(done), 32'h1);
        check({tag, " data"}, load_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick();
        tick();
        check("rst busy", 32'(lsu_busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst req", 32'(mem_req), 32'h0);
        check("rst addr", mem_addr, 32'h0);
        check("rst wstrb", 32'(mem_wstrb), 32'h0);
        check("rst wdata", mem_wdata, 32'h0);
        check("rst ldata", load_data, 32'h0);
        check("rst flags", 32'({misaligned, access_err}), 32'h0);
        reset_n = 1'b1;
        tick();

        issue(1'b1, F3_W, 32'h100, 32'hDEADBEEF);
        check("sw req", 32'(mem_req), 32'h1);
        check("sw we", 32'(mem_we), 32'h1);
        check("sw addr", mem_addr, 32'h100);
        check("sw wstrb", 32'(mem_wstrb), 32'hF);
        check("sw wdata", mem_wdata, 32'hDEADBEEF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sw wait req", 32'(mem_req), 32'h0);
        check("sw wait done", 32'(done), 32'h0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("sw done", 32'(done), 32'h1);
        check("sw flags", 32'({misaligned, access_err}), 32'h0);
        check("sw ldata", load_data, 32'h0);
        tick();
        check("sw done drop", 32'(done), 32'h0);
        check("sw idle", 32'(lsu_busy), 32'h0);

        load_fast("lb", F3_B, 32'h203, 32'h80FFFFFF, 32'hFFFFFF80);
        load_fast("lbu", F3_BU, 32'h203, 32'h80FFFFFF, 32'h00000080);
        load_fast("lhu", F3_HU, 32'h202, 32'h8001ABCD, 32'h00008001);
        load_fast("lh", F3_H, 32'h202, 32'h8001ABCD, 32'hFFFF8001);
        load_fast("lh0", F3_H, 32'h200, 32'h8001ABCD, 32'hFFFFABCD);
        load_fast("lb1", F3_B, 32'h201, 32'h00003400, 32'h00000034);
        load_fast("lw", F3_W, 32'h204, 32'h13579BDF, 32'h13579BDF);

        issue(1'b1, F3_H, 32'h101, 32'h0);
        check("sh mis done", 32'(done), 32'h1);
        check("sh mis flag", 32'(misaligned), 32'h1);
        check("sh mis err", 32'(access_err), 32'h0);
        check("sh mis req", 32'(mem_req), 32'h0);
        tick();
        check("sh mis drop", 32'(done), 32'h0);

        issue(1'b0, 3'b011, 32'h100, 32'h0);
        check("ill done", 32'(done), 32'h1);
        check("ill err", 32'(access_err), 32'h1);
        check("ill mis", 32'(misaligned), 32'h0);
        check("ill req", 32'(mem_req), 32'h0);
        tick();

        issue(1'b1, 3'b100, 32'h101, 32'h0);
        check("sill err", 32'(access_err), 32'h1);
        check("sill mis", 32'(misaligned), 32'h0);
        tick();

        issue(1'b0, F3_W, 32'h102, 32'h0);
        check("lw mis", 32'(misaligned), 32'h1);
        check("lw mis err", 32'(access_err), 32'h0);
        tick();

        issue(1'b1, F3_B, 32'h2, 32'h12345678);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            check("sb req", 32'(mem_req), 32'h1);
            check("sb busy", 32'(lsu_busy), 32'h1);
            if (mem_req) n++;
            if (i == 2) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        check("sb req cycles", 32'(n), 32'd3);
        check("sb wait req", 32'(mem_req), 32'h0);
        check("sb wait busy", 32'(lsu_busy), 32'h1);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("sb done", 32'(done), 32'h1);
        tick();

        issue(1'b1, F3_B, 32'h2, 32'h12345678);
        check("sb wstrb", 32'(mem_wstrb), 32'h4);
        check("sb wdata", mem_wdata, 32'h78787878);
        check("sb addr", mem_addr, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();

        issue(1'b1, F3_H, 32'h102, 32'hCAFEBEEF);
        check("sh wstrb", 32'(mem_wstrb), 32'hC);
        check("sh wdata", mem_wdata, 32'hBEEFBEEF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("sh done", 32'(done), 32'h1);
        tick();

        issue(1'b0, F3_W, 32'h300, 32'h0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("to cycles", 32'(n), 32'd16);
        check("to err", 32'(access_err), 32'h1);
        check("to req", 32'(mem_req), 32'h0);
        check("to ldata", load_data, 32'h0);
        tick();

        issue(1'b0, F3_W, 32'h300, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (14) tick();
        check("to2 pre", 32'(done), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        check("to2 done", 32'(done), 32'h1);
        check("to2 err", 32'(access_err), 32'h0);
        check("to2 data", load_data, 32'hCAFEF00D);
        tick();

        issue(1'b0, F3_W, 32'h400, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rm wait busy", 32'(lsu_busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rm async busy", 32'(lsu_busy), 32'h0);
        check("rm async req", 32'(mem_req), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0000FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("rm stray done", 32'(done), 32'h0);
        tick();
        check("rm stray done2", 32'(done), 32'h0);
        check("rm idle", 32'(lsu_busy), 32'h0);
        load_fast("rm lw", F3_W, 32'h10, 32'h11223344, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
